// File: rtl/scan_sequencer_pkg.sv
// Shared types and default widths for the film-scan pass sequencer.
package scan_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LED_UP,
        SETTLE,
        SCAN,
        LED_DOWN
    } state_t;

    localparam int DEF_LED_W    = 16;
    localparam int DEF_SPD_W    = 16;
    localparam int DEF_LINE_W   = 16;
    localparam int DEF_SETTLE_W = 24;
    localparam int DEF_RAMP_DIV = 256;

endpackage

// File: rtl/scan_sequencer_led_ramp.sv
// LED level ramp: prescaler down-counter gating unit steps toward target (up) or 0 (down).
module led_ramp #(
    parameter int LED_W    = 16,
    parameter int RAMP_DIV = 256
) (
    input  logic             bus_clk,
    input  logic             rst,
    input  logic [LED_W-1:0] target,
    input  logic             dir_up,
    input  logic             run,
    output logic [LED_W-1:0] value,
    output logic             at_target
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(RAMP_DIV - 1);

    logic [DIV_W-1:0] pre_cnt;

    assign at_target = dir_up ? (value == target) : (value == '0);

    // Dropping run reloads the prescaler, so each ramp phase starts a full period late.
    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= DIV_LOAD;
            value   <= '0;
        end else if (!run) begin
            pre_cnt <= DIV_LOAD;
        end else if (pre_cnt == '0) begin
            pre_cnt <= DIV_LOAD;
            if (!at_target) begin
                value <= dir_up ? value + LED_W'(1) : value - LED_W'(1);
            end
        end else begin
            pre_cnt <= pre_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// One film-scan pass: LED ramp up, motor settle, line capture, motor stop and LED ramp down.
module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int LED_W    = DEF_LED_W,
    parameter int SPD_W    = DEF_SPD_W,
    parameter int LINE_W   = DEF_LINE_W,
    parameter int SETTLE_W = DEF_SETTLE_W,
    parameter int RAMP_DIV = DEF_RAMP_DIV
) (
    input  logic                bus_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [LED_W-1:0]    cfg_led_target,
    input  logic [SPD_W-1:0]    cfg_mtr_speed,
    input  logic                cfg_mtr_dir,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic [LINE_W-1:0]   cfg_num_lines,
    input  logic                line_done,
    output logic [LED_W-1:0]    led_pwm_val,
    output logic                mtr_en,
    output logic                mtr_dir,
    output logic [SPD_W-1:0]    mtr_speed,
    output logic                scan_en,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [LINE_W-1:0]   line_cnt
);

    state_t state, next_state;

    logic [LED_W-1:0]    led_target;
    logic [SPD_W-1:0]    speed_lat;
    logic                dir_lat;
    logic [SETTLE_W-1:0] settle_lat;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [LINE_W-1:0]   lines_lat;
    logic                abort_flag;
    logic                ramp_run;
    logic                ramp_up;
    logic                at_target;
    logic                go;
    logic                halt;
    logic                line_inc;
    logic                settle_tc;
    logic                scan_tc;
    logic                motor_on;

    led_ramp #(
        .LED_W    (LED_W),
        .RAMP_DIV (RAMP_DIV)
    ) u_led_ramp (
        .bus_clk   (bus_clk),
        .rst       (rst),
        .target    (led_target),
        .dir_up    (ramp_up),
        .run       (ramp_run),
        .value     (led_pwm_val),
        .at_target (at_target)
    );

    always_comb begin
        go        = start && !abort;
        halt      = abort && (state inside {LED_UP, SETTLE, SCAN});
        line_inc  = (state == SCAN) && line_done && !abort && (line_cnt < lines_lat);
        settle_tc = (settle_cnt <= SETTLE_W'(1));
        scan_tc   = (line_cnt >= lines_lat) ||
                    (line_inc && ((line_cnt + LINE_W'(1)) == lines_lat));

        next_state = state;
        case (state)
            IDLE:     if (go) next_state = LED_UP;
            LED_UP:   if (halt) next_state = LED_DOWN;
                      else if (at_target) next_state = SETTLE;
            SETTLE:   if (halt) next_state = LED_DOWN;
                      else if (settle_tc) next_state = SCAN;
            SCAN:     if (halt || scan_tc) next_state = LED_DOWN;
            LED_DOWN: if (at_target) next_state = IDLE;
            default:  next_state = IDLE;
        endcase

        // Ramp is held off on the exit cycle so the next phase's prescaler restarts on entry.
        ramp_run = (state inside {LED_UP, LED_DOWN}) && (next_state == state);
        ramp_up  = (state == LED_UP);
        motor_on = (next_state inside {SETTLE, SCAN});
    end

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            led_target <= '0;
            speed_lat  <= '0;
            dir_lat    <= 1'b0;
            settle_lat <= '0;
            lines_lat  <= '0;
            settle_cnt <= '0;
            abort_flag <= 1'b0;
            line_cnt   <= '0;
            mtr_en     <= 1'b0;
            mtr_dir    <= 1'b0;
            mtr_speed  <= '0;
            scan_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state   <= next_state;
            done    <= 1'b0;
            aborted <= 1'b0;

            if (state == IDLE && go) begin
                led_target <= cfg_led_target;
                speed_lat  <= cfg_mtr_speed;
                dir_lat    <= cfg_mtr_dir;
                settle_lat <= cfg_settle;
                lines_lat  <= cfg_num_lines;
                line_cnt   <= '0;
                abort_flag <= 1'b0;
            end else if (abort && state != IDLE) begin
                abort_flag <= 1'b1;
            end

            if (next_state == SETTLE && state != SETTLE) begin
                settle_cnt <= settle_lat;
            end else if (state == SETTLE && !settle_tc) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end

            if (line_inc) begin
                line_cnt <= line_cnt + LINE_W'(1);
            end

            mtr_en    <= motor_on;
            mtr_speed <= motor_on ? speed_lat : '0;
            if (motor_on) begin
                mtr_dir <= dir_lat;
            end
            scan_en <= (next_state == SCAN);
            busy    <= (next_state != IDLE);

            if (state == LED_DOWN && next_state == IDLE) begin
                done    <= !(abort_flag || abort);
                aborted <= abort_flag || abort;
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: per-cycle vector table plus hand-written multi-cycle passes.
module tb_scan_sequencer;

    logic        bus_clk = 1'b0;
    logic        rst, start, abort, line_done, cfg_mtr_dir;
    logic [15:0] cfg_led_target, cfg_mtr_speed, cfg_num_lines;
    logic [23:0] cfg_settle;
    logic [15:0] led_pwm_val, mtr_speed, line_cnt;
    logic        mtr_en, mtr_dir, scan_en, busy, done, aborted;

    int tests = 0;
    int fails = 0;

    scan_sequencer #(
        .LED_W(16), .SPD_W(16), .LINE_W(16), .SETTLE_W(24), .RAMP_DIV(4)
    ) dut (
        .bus_clk        (bus_clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_led_target (cfg_led_target),
        .cfg_mtr_speed  (cfg_mtr_speed),
        .cfg_mtr_dir    (cfg_mtr_dir),
        .cfg_settle     (cfg_settle),
        .cfg_num_lines  (cfg_num_lines),
        .line_done      (line_done),
        .led_pwm_val    (led_pwm_val),
        .mtr_en         (mtr_en),
        .mtr_dir        (mtr_dir),
        .mtr_speed      (mtr_speed),
        .scan_en        (scan_en),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .line_cnt       (line_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic        line_done;
        logic        busy;
        logic        done;
        logic        mtr_en;
        logic        scan_en;
        logic [15:0] led;
        logic [15:0] spd;
        logic [15:0] lc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] tgt, input logic [23:0] st, input logic [15:0] nl,
                           input logic [15:0] spd, input logic dir);
        cfg_led_target = tgt;
        cfg_settle     = st;
        cfg_num_lines  = nl;
        cfg_mtr_speed  = spd;
        cfg_mtr_dir    = dir;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_hi(input bit want_scan, input string name);
        int n = 0;
        while (((want_scan ? scan_en : mtr_en) == 1'b0) && n < 100) begin
            tick();
            n++;
        end
        chk(name, 32'(want_scan ? scan_en : mtr_en), 32'd1);
    endtask

    task automatic finish_pass(input string name, output int nd, output int na);
        int n = 0;
        nd = 0;
        na = 0;
        while (n < 60) begin
            tick();
            n++;
            if (done) nd++;
            if (aborted) na++;
            if (!busy) break;
        end
        chk({name, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int nd, na;
        rst = 1'b1; start = 1'b0; abort = 1'b0; line_done = 1'b0;
        set_cfg(16'd0, 24'd0, 16'd0, 16'd0, 1'b0);
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_led", 32'(led_pwm_val), 32'd0);
        chk("rst_mtr_en", 32'(mtr_en), 32'd0);
        chk("rst_line_cnt", 32'(line_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Zero-length config, plus start+abort and lone abort in IDLE.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 16'h0055, 16'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 16'h0055, 16'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd0};
        set_cfg(16'd0, 24'd0, 16'd0, 16'h0055, 1'b0);
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start; abort = vecs[i].abort; line_done = vecs[i].line_done;
            tick();
            start = 1'b0; abort = 1'b0; line_done = 1'b0;
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d_mtr_en", i), 32'(mtr_en), 32'(vecs[i].mtr_en));
            chk($sformatf("vec%0d_scan_en", i), 32'(scan_en), 32'(vecs[i].scan_en));
            chk($sformatf("vec%0d_led", i), 32'(led_pwm_val), 32'(vecs[i].led));
            chk($sformatf("vec%0d_speed", i), 32'(mtr_speed), 32'(vecs[i].spd));
            chk($sformatf("vec%0d_line_cnt", i), 32'(line_cnt), 32'(vecs[i].lc));
        end

        // Normal pass, with a start and num_lines change during LED_UP that must be ignored.
        set_cfg(16'd3, 24'd10, 16'd5, 16'h1234, 1'b1);
        pulse_start();                                   // k=0
        chk("np_busy", 32'(busy), 32'd1);
        repeat (3) tick();                               // k=3
        chk("np_led_k3", 32'(led_pwm_val), 32'd0);
        tick();                                          // k=4
        chk("np_led_k4", 32'(led_pwm_val), 32'd1);
        cfg_num_lines = 16'd9;
        pulse_start();                                   // k=5
        chk("np_led_k5", 32'(led_pwm_val), 32'd1);
        repeat (3) tick();                               // k=8
        chk("np_led_k8", 32'(led_pwm_val), 32'd2);
        repeat (4) tick();                               // k=12
        chk("np_led_k12", 32'(led_pwm_val), 32'd3);
        chk("np_mtr_en_k12", 32'(mtr_en), 32'd0);
        tick();                                          // k=13
        chk("np_mtr_en_k13", 32'(mtr_en), 32'd1);
        chk("np_scan_en_k13", 32'(scan_en), 32'd0);
        chk("np_speed", 32'(mtr_speed), 32'h1234);
        chk("np_dir", 32'(mtr_dir), 32'd1);
        repeat (9) tick();                               // k=22
        chk("np_scan_en_k22", 32'(scan_en), 32'd0);
        tick();                                          // k=23
        chk("np_scan_en_k23", 32'(scan_en), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            repeat (19) tick();
            line_done = 1'b1;
            tick();
            line_done = 1'b0;
            chk($sformatf("np_line_cnt_%0d", i), 32'(line_cnt), 32'(i));
            chk($sformatf("np_scan_en_%0d", i), 32'(scan_en), 32'(i < 5));
        end
        chk("np_down_mtr_en", 32'(mtr_en), 32'd0);
        chk("np_down_speed", 32'(mtr_speed), 32'd0);
        chk("np_down_dir", 32'(mtr_dir), 32'd1);
        chk("np_down_led", 32'(led_pwm_val), 32'd3);
        repeat (3) tick();
        chk("np_down_led_3", 32'(led_pwm_val), 32'd3);
        tick();
        chk("np_down_led_4", 32'(led_pwm_val), 32'd2);
        finish_pass("np", nd, na);
        chk("np_done_count", 32'(nd), 32'd1);
        chk("np_aborted_count", 32'(na), 32'd0);
        chk("np_final_led", 32'(led_pwm_val), 32'd0);
        chk("np_final_line_cnt", 32'(line_cnt), 32'd5);
        tick();
        chk("np_done_single", 32'(done), 32'd0);

        // Abort during SCAN after two lines.
        set_cfg(16'd3, 24'd2, 16'd5, 16'h0777, 1'b0);
        pulse_start();
        chk("ab_line_cnt_clear", 32'(line_cnt), 32'd0);
        wait_hi(1'b1, "ab_reach_scan");
        for (int i = 0; i < 2; i++) begin
            line_done = 1'b1;
            tick();
            line_done = 1'b0;
            tick(); tick();
        end
        chk("ab_line_cnt_2", 32'(line_cnt), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_scan_en", 32'(scan_en), 32'd0);
        chk("ab_mtr_en", 32'(mtr_en), 32'd0);
        chk("ab_led_hold", 32'(led_pwm_val), 32'd3);
        chk("ab_busy", 32'(busy), 32'd1);
        finish_pass("ab", nd, na);
        chk("ab_done_count", 32'(nd), 32'd0);
        chk("ab_aborted_count", 32'(na), 32'd1);
        chk("ab_final_led", 32'(led_pwm_val), 32'd0);
        chk("ab_final_line_cnt", 32'(line_cnt), 32'd2);

        // line_done coincident with abort in SCAN: abort wins, no count.
        set_cfg(16'd1, 24'd1, 16'd4, 16'h0001, 1'b1);
        pulse_start();
        wait_hi(1'b1, "la_reach_scan");
        line_done = 1'b1; abort = 1'b1;
        tick();
        line_done = 1'b0; abort = 1'b0;
        chk("la_line_cnt", 32'(line_cnt), 32'd0);
        chk("la_scan_en", 32'(scan_en), 32'd0);
        finish_pass("la", nd, na);
        chk("la_aborted_count", 32'(na), 32'd1);

        // Asynchronous reset while in SETTLE, then a fresh full pass.
        set_cfg(16'd1, 24'd50, 16'd2, 16'h0abc, 1'b1);
        pulse_start();
        wait_hi(1'b0, "rs_reach_settle");
        #2 rst = 1'b1;
        #1;
        chk("rs_mtr_en", 32'(mtr_en), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_led", 32'(led_pwm_val), 32'd0);
        chk("rs_speed", 32'(mtr_speed), 32'd0);
        chk("rs_dir", 32'(mtr_dir), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_aborted", 32'(aborted), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rs_idle", 32'(busy), 32'd0);
        set_cfg(16'd2, 24'd3, 16'd2, 16'h0abc, 1'b1);
        pulse_start();
        nd = 0;
        na = 0;
        for (int n = 0; n < 100; n++) begin
            line_done = scan_en;
            tick();
            line_done = 1'b0;
            if (aborted) na++;
            if (done) begin
                nd++;
                break;
            end
        end
        chk("rs_pass_done", 32'(nd), 32'd1);
        chk("rs_pass_aborted", 32'(na), 32'd0);
        chk("rs_pass_line_cnt", 32'(line_cnt), 32'd2);
        chk("rs_pass_led", 32'(led_pwm_val), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
